core_sequencer: RTL
===================

Name: core_sequencer

Overview:
- Multi-cycle control FSM for the RISCV_core datapath: ProgramCounter, InstructionMemory, Decoder, RegisterFile, ALU and write-data mux.
- Issues one-cycle strobes that update the PC, latch the instruction register, write the register file and request data memory, so each instruction takes several cycles instead of one.
- Adds run/halt/single-step debug control, a memory-timeout trap, and cycle and retired-instruction counters.
- Sits between the core top level and the existing datapath blocks.

Parameters:
- CNT_W, 32, width of cycle_count and instret_count.
- MEM_TIMEOUT, 15, maximum wait cycles on imem_ready or dmem_ack before trapping.
- TO_W, 4, width of the timeout counter. Must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run enable; 0 holds the FSM in IDLE.
- step_mode  input  1  1 = single-step: halt after each retired instruction.
- step_req  input  1  one-cycle pulse that releases HALT for one instruction.
- imem_ready  input  1  instruction memory data valid.
- inst_class  input  3  from Decoder: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 UPPER, 7 ILLEGAL, 6 reserved (treated as ILLEGAL).
- dmem_ack  input  1  data memory transfer complete.
- ir_load  output  1  latch instruction register (1-cycle strobe).
- pc_en  output  1  advance/update PC (1-cycle strobe).
- rf_wr_en  output  1  register-file write strobe.
- dmem_req  output  1  data memory request; held until ack.
- dmem_we  output  1  write qualifier for dmem_req.
- halted  output  1  FSM is in HALT.
- trap  output  1  sticky; set on illegal instruction or timeout.
- trap_cause  output  2  1 = illegal, 2 = imem timeout, 3 = dmem timeout.
- state  output  3  current state encoding, for debug.
- cycle_count  output  CNT_W  counts cycles while not IDLE/HALT.
- instret_count  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (checked on the clk edge only):
  - State goes to IDLE.
  - All strobes, dmem_req, dmem_we, halted, trap, trap_cause and both counters go to 0.
  - Reset takes priority over everything else, including mid-transaction: dmem_req drops in the next cycle.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE -> FETCH when enable=1; otherwise stay in IDLE.
- FETCH:
  - Wait for imem_ready=1, then assert ir_load for one cycle and go to DECODE.
  - Timeout counter is cleared on entry and increments on each waiting cycle.
  - If it reaches MEM_TIMEOUT with imem_ready still 0: trap=1, cause=2, go to HALT.
- DECODE:
  - Always exactly one cycle.
  - inst_class 6 or 7: trap=1, cause=1, go to HALT. No strobes, no retire.
  - Otherwise go to EXEC.
- EXEC is one cycle:
  - LOAD/STORE: go to MEM; dmem_req=1 from the first MEM cycle; dmem_we=1 only for STORE.
  - ALU/UPPER/JUMP: go to WB.
  - BRANCH: assert pc_en in this cycle (ProgramCounter resolves taken/not-taken from its own inputs) and retire. Next state is HALT if step_mode=1, else FETCH.
- MEM:
  - Hold dmem_req/dmem_we until dmem_ack=1.
  - The cycle after ack: dmem_req=0 and next state is WB for LOAD. For STORE, assert pc_en, retire, then go to FETCH or HALT per the step rule.
  - Timeout as in FETCH: cause=3, go to HALT, dmem_req drops.
- WB:
  - One cycle; assert rf_wr_en and pc_en together, retire.
  - Next state: HALT if step_mode=1, else FETCH.
- Retire: instret_count increments in the same cycle as the final pc_en.
- HALT:
  - halted=1 and all strobes are 0.
  - With trap=0: step_req=1 -> FETCH. Alternatively step_mode=0 with enable=1 -> FETCH.
  - With trap=1: stay in HALT until reset.
- enable:
  - enable=0 in any non-IDLE state is honoured only at an instruction boundary (the point where FETCH would be entered). The FSM goes to IDLE instead, so no instruction is ever half-executed.
  - step_req while not in HALT is ignored.
- Counters:
  - cycle_count increments in every cycle where state is not IDLE or HALT.
  - Both counters wrap modulo 2^CNT_W with no saturation.
- Strobe invariants:
  - Outputs are registered (Moore) and every strobe is exactly one cycle wide.
  - pc_en is asserted exactly once per retired instruction.
  - ir_load is asserted exactly once per fetch.
- Latencies with imem_ready=1 and zero-wait ack: ALU 4 cycles (FETCH to WB), BRANCH 3, LOAD 5, STORE 4.

Test Plan:
- reset; enable=1; imem_ready=1; ten ALU instructions -> instret_count=10, cycle_count=40, ten rf_wr_en pulses each coincident with pc_en, ir_load pulses spaced 4 cycles apart.
- LOAD with dmem_ack delayed by 3 cycles -> dmem_req high for 4 cycles, dmem_we=0, then rf_wr_en once. STORE -> dmem_we=1, no rf_wr_en.
- imem_ready held at 0 -> after 15 wait cycles, trap=1, trap_cause=2, halted=1. A later step_req is ignored; reset clears the trap.
- inst_class=7 -> next cycle trap_cause=1, HALT, no pc_en, instret_count unchanged.
- step_mode=1, two step_req pulses spaced 20 cycles apart -> exactly two instructions retire and halted=1 between them.
- reset asserted in MEM with dmem_req=1 -> next cycle dmem_req=0, state=IDLE, counters=0. Also check counter wrap with CNT_W=4: 16 retired instructions -> instret_count=0.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RISC-V control FSM issuing registered PC/IR/RF/dmem strobes with debug halt, timeout trap and counters
module core_sequencer #(
  parameter int CNT_W = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             imem_ready,
  input  logic [2:0]       inst_class,
  input  logic             dmem_ack,
  output logic             ir_load,
  output logic             pc_en,
  output logic             rf_wr_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t cur, nxt, boundary, after_retire;
  logic [TO_W-1:0] to_cnt;
  logic timed_out, ir_load_n, pc_en_n, rf_wr_en_n, dmem_req_n, dmem_we_n, trap_n;
  logic [1:0] cause_n;
  assign state = cur;
  assign timed_out = to_cnt == TO_W'(MEM_TIMEOUT - 1);
  assign boundary = enable ? FETCH : IDLE;
  assign after_retire = step_mode ? HALT : boundary;
  always_comb begin
    nxt = cur;
    ir_load_n = 1'b0;
    pc_en_n = 1'b0;
    rf_wr_en_n = 1'b0;
    dmem_req_n = 1'b0;
    dmem_we_n = 1'b0;
    trap_n = trap;
    cause_n = trap_cause;
    case (cur)
      IDLE: nxt = enable ? FETCH : IDLE;
      FETCH:
        if (imem_ready) begin
          nxt = DECODE;
          ir_load_n = 1'b1;
        end else if (timed_out) begin
          nxt = HALT;
          trap_n = 1'b1;
          cause_n = 2'd2;
        end
      DECODE:
        if (inst_class[2:1] == 2'b11) begin
          nxt = HALT;
          trap_n = 1'b1;
          cause_n = 2'd1;
        end else begin
          nxt = EXEC;
          // a branch retires during EXEC, so its pc_en is registered one edge early
          pc_en_n = inst_class == 3'd3;
        end
      EXEC:
        if (inst_class == 3'd1 || inst_class == 3'd2) begin
          nxt = MEM;
          dmem_req_n = 1'b1;
          dmem_we_n = inst_class == 3'd2;
        end else if (inst_class == 3'd3) nxt = after_retire;
        else begin
          nxt = WB;
          rf_wr_en_n = 1'b1;
          pc_en_n = 1'b1;
        end
      MEM:
        if (dmem_ack) begin
          // dmem_we still remembers whether this is a store
          nxt = dmem_we ? after_retire : WB;
          pc_en_n = 1'b1;
          rf_wr_en_n = !dmem_we;
        end else if (timed_out) begin
          nxt = HALT;
          trap_n = 1'b1;
          cause_n = 2'd3;
        end else begin
          dmem_req_n = 1'b1;
          dmem_we_n = dmem_we;
        end
      WB: nxt = after_retire;
      HALT: nxt = (!trap && (step_req || (!step_mode && enable))) ? boundary : HALT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= IDLE;
      to_cnt <= '0;
      ir_load <= 1'b0;
      pc_en <= 1'b0;
      rf_wr_en <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      halted <= 1'b0;
      trap <= 1'b0;
      trap_cause <= 2'd0;
      cycle_count <= '0;
      instret_count <= '0;
    end else begin
      cur <= nxt;
      to_cnt <= (nxt != cur) ? '0 : (cur == FETCH || cur == MEM) ? to_cnt + 1'b1 : to_cnt;
      ir_load <= ir_load_n;
      pc_en <= pc_en_n;
      rf_wr_en <= rf_wr_en_n;
      dmem_req <= dmem_req_n;
      dmem_we <= dmem_we_n;
      halted <= nxt == HALT;
      trap <= trap_n;
      trap_cause <= cause_n;
      cycle_count <= cycle_count + CNT_W'(cur != IDLE && cur != HALT);
      instret_count <= instret_count + CNT_W'(pc_en_n);
    end
  end
endmodule
